// File: rtl/avm_rd_arbiter.sv
// avm_rd_arbiter: two-master round-robin Avalon-MM read arbiter with in-order response routing
module avm_rd_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            m0_address,
  input  logic                         m0_read,
  output logic                         m0_waitrequest,
  output logic [DATA_W-1:0]            m0_readdata,
  output logic                         m0_readdatavalid,
  input  logic [ADDR_W-1:0]            m1_address,
  input  logic                         m1_read,
  output logic                         m1_waitrequest,
  output logic [DATA_W-1:0]            m1_readdata,
  output logic                         m1_readdatavalid,
  output logic [ADDR_W-1:0]            s_address,
  output logic                         s_read,
  input  logic                         s_waitrequest,
  input  logic [DATA_W-1:0]            s_readdata,
  input  logic                         s_readdatavalid,
  output logic [$clog2(MAX_OUT):0]     outstanding,
  output logic                         err_unexpected
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  logic          fifo_q [MAX_OUT];
  logic [PW-1:0] wp, rp;
  logic          lock, locked_id, last_grant;
  logic          full, empty, gnt_v, gnt, head, accept, pop;
  assign full   = outstanding == CW'(MAX_OUT);
  assign empty  = outstanding == '0;
  assign gnt_v  = lock | m0_read | m1_read;
  // a stalled grant is held so the address cannot switch under waitrequest
  assign gnt    = lock ? locked_id : (m0_read & m1_read) ? ~last_grant : m1_read;
  assign s_read = gnt_v & (gnt ? m1_read : m0_read) & ~full & ~rst;
  assign s_address = !gnt_v ? '0 : gnt ? m1_address : m0_address;
  assign m0_waitrequest = ~(gnt_v & ~gnt) | s_waitrequest | full | rst;
  assign m1_waitrequest = ~(gnt_v & gnt) | s_waitrequest | full | rst;
  assign accept = s_read & ~s_waitrequest;
  assign pop    = s_readdatavalid & ~empty & ~rst;
  assign head   = fifo_q[rp];
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;
  always_ff @(posedge clk)
    if (accept) fifo_q[wp] <= gnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding    <= '0;
      wp             <= '0;
      rp             <= '0;
      lock           <= 1'b0;
      locked_id      <= 1'b0;
      last_grant     <= 1'b1;
      err_unexpected <= 1'b0;
    end else begin
      if (accept) begin
        wp         <= wp + 1'b1;
        last_grant <= gnt;
        lock       <= 1'b0;
      end else if (s_read) begin
        lock      <= 1'b1;
        locked_id <= gnt;
      end
      if (pop) rp <= rp + 1'b1;
      outstanding <= outstanding + CW'(accept) - CW'(pop);
      if (s_readdatavalid & empty) err_unexpected <= 1'b1;
    end
  end
endmodule
